sha3_scan_request_loader: RTL and testbench

- Upstream neighbour of the SHA3 scanner control block.
- Receives scan jobs as framed 32-bit words from the host link (valid/ready/last stream) and assembles the 24-word block template plus 64-bit difficulty threshold.
- Double-buffers the job: the next frame may be collected while the scanner runs. The committed template/threshold stay stable until the next start, because the scanner compares against threshold for the whole scan.
- Issues a one-cycle start pulse only when the scanner reports ready.

---
 rtl/sha3_scan_request_loader_if.sv | 11 +
 rtl/sha3_scan_request_loader.sv | 120 ++++++++++++
 tb/tb_sha3_scan_request_loader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_scan_request_loader_if.sv
// Host-link word stream into the scan request loader: 32-bit data with
// valid/ready/last framing.
interface sha3_scan_request_loader_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;

  modport master (output in_data, output in_valid, output in_last, input in_ready);
  modport slave  (input in_data, input in_valid, input in_last, output in_ready);
endinterface

// File: rtl/sha3_scan_request_loader.sv
// Assembles framed scan jobs into a shadow block template/threshold and commits
// them to the SHA3 scanner with a one-cycle start pulse when the scanner is idle.
module sha3_scan_request_loader #(
  parameter logic [31:0] MAGIC         = 32'h53484133,
  parameter int          COUNTER_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  sha3_scan_request_loader_if.slave in_bus,
  input  logic                     scanner_ready,
  output logic                     ostart,
  output logic [767:0]             oblock_template,
  output logic [63:0]              othreshold,
  output logic                     opending,
  output logic [COUNTER_WIDTH-1:0] oframes_ok,
  output logic [COUNTER_WIDTH-1:0] oframes_bad
);

  typedef enum logic [1:0] {
    s_hunt,
    s_collect,
    s_pending,
    s_start
  } state_t;

  localparam logic [COUNTER_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  state_t             state;
  logic [4:0]         word_cnt;
  logic [23:0][31:0]  shadow_template;
  logic [63:0]        shadow_threshold;
  logic               in_ready_q;
  logic               xfer;

  assign in_bus.in_ready = in_ready_q;
  assign xfer            = in_bus.in_valid & in_ready_q;

  // in_ready and opending are registered alongside the state so every output
  // comes straight from a flop; in_ready stays low for the first cycle after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= s_hunt;
      word_cnt         <= 5'd0;
      shadow_template  <= '0;
      shadow_threshold <= '0;
      in_ready_q       <= 1'b0;
      ostart           <= 1'b0;
      opending         <= 1'b0;
      oblock_template  <= '0;
      othreshold       <= '0;
      oframes_ok       <= '0;
      oframes_bad      <= '0;
    end else begin
      case (state)
        s_hunt: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            if (in_bus.in_data == MAGIC && !in_bus.in_last) begin
              state    <= s_collect;
              word_cnt <= 5'd1;
            end else if (oframes_bad != CNT_MAX) begin
              oframes_bad <= oframes_bad + CNT_ONE;
            end
          end
        end

        s_collect: begin
          if (xfer) begin
            if (word_cnt == 5'd26) begin
              shadow_threshold[63:32] <= in_bus.in_data;
              if (in_bus.in_last) begin
                state      <= s_pending;
                in_ready_q <= 1'b0;
                opending   <= 1'b1;
              end else begin
                state    <= s_hunt;
                word_cnt <= 5'd0;
                if (oframes_bad != CNT_MAX) oframes_bad <= oframes_bad + CNT_ONE;
              end
            end else if (in_bus.in_last) begin
              state    <= s_hunt;
              word_cnt <= 5'd0;
              if (oframes_bad != CNT_MAX) oframes_bad <= oframes_bad + CNT_ONE;
            end else begin
              if (word_cnt == 5'd25) shadow_threshold[31:0] <= in_bus.in_data;
              else shadow_template[word_cnt - 5'd1] <= in_bus.in_data;
              word_cnt <= word_cnt + 5'd1;
            end
          end
        end

        s_pending: begin
          if (scanner_ready) begin
            oblock_template <= shadow_template;
            othreshold      <= shadow_threshold;
            ostart          <= 1'b1;
            opending        <= 1'b0;
            state           <= s_start;
            if (oframes_ok != CNT_MAX) oframes_ok <= oframes_ok + CNT_ONE;
          end
        end

        s_start: begin
          ostart     <= 1'b0;
          state      <= s_hunt;
          word_cnt   <= 5'd0;
          in_ready_q <= 1'b1;
        end

        default: begin
          state      <= s_hunt;
          word_cnt   <= 5'd0;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_scan_request_loader.sv
// Scoreboard bench for the scan request loader: each good frame pushes its
// expected template/threshold, each ostart pulse pops and compares.
module tb_sha3_scan_request_loader;
  localparam logic [31:0] MAGIC = 32'h53484133;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        scanner_ready = 1'b0;
  logic        ostart;
  logic [767:0] oblock_template;
  logic [63:0] othreshold;
  logic        opending;
  logic [15:0] oframes_ok;
  logic [15:0] oframes_bad;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [831:0] exp_q[$];
  logic [831:0] sb_entry;

  sha3_scan_request_loader_if bus();

  sha3_scan_request_loader #(.MAGIC(MAGIC), .COUNTER_WIDTH(16)) dut (
    .clk(clk),
    .rst(rst),
    .in_bus(bus),
    .scanner_ready(scanner_ready),
    .ostart(ostart),
    .oblock_template(oblock_template),
    .othreshold(othreshold),
    .opending(opending),
    .oframes_ok(oframes_ok),
    .oframes_bad(oframes_bad)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [767:0] got, input logic [767:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [767:0] make_tpl(input logic [31:0] base);
    logic [767:0] t;
    for (int k = 0; k < 24; k++) t[32*k +: 32] = base + k;
    return t;
  endfunction

  task automatic send_word(input logic [31:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    bus.in_data  = d;
    bus.in_valid = 1'b1;
    bus.in_last  = last;
    while (!bus.in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) checkOutput("ready_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] base, input logic [63:0] thr, input bit push);
    if (push) exp_q.push_back({thr, make_tpl(base)});
    send_word(MAGIC, 1'b0);
    for (int k = 0; k < 24; k++) send_word(base + k, 1'b0);
    send_word(thr[31:0], 1'b0);
    send_word(thr[63:32], 1'b1);
  endtask

  // Every start pulse cycle must match the oldest committed-frame expectation.
  always @(negedge clk) begin
    if (!rst && ostart) begin
      pulses++;
      if (exp_q.size() == 0) begin
        checkOutput("sb_unexpected_start", 1, 0);
      end else begin
        sb_entry = exp_q.pop_front();
        checkOutput("sb_template", oblock_template, sb_entry[767:0]);
        checkOutput("sb_threshold", othreshold, sb_entry[831:768]);
      end
    end
  end

  initial begin
    bus.in_data  = '0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset_ostart", ostart, 0);
    checkOutput("reset_opending", opending, 0);
    checkOutput("reset_in_ready", bus.in_ready, 0);
    checkOutput("reset_template", oblock_template, 0);
    checkOutput("reset_threshold", othreshold, 0);
    checkOutput("reset_ok", oframes_ok, 0);
    checkOutput("reset_bad", oframes_bad, 0);
    rst = 1'b0;

    // Good frame with the scanner already idle: pulse two cycles after last word.
    scanner_ready = 1'b1;
    send_frame(32'h1000, 64'h00000FFF_FFFFFFFF, 1'b1);
    @(negedge clk);
    checkOutput("c1_opending", opending, 1);
    checkOutput("c1_ostart", ostart, 0);
    checkOutput("c1_in_ready", bus.in_ready, 0);
    @(negedge clk);
    checkOutput("c2_ostart", ostart, 1);
    @(negedge clk);
    checkOutput("c3_ostart", ostart, 0);
    checkOutput("c3_opending", opending, 0);
    checkOutput("a_word5", oblock_template[191:160], 32'h1005);
    checkOutput("a_threshold", othreshold, 64'h00000FFF_FFFFFFFF);
    checkOutput("a_ok", oframes_ok, 1);

    // Scanner busy: the frame waits in pending with input held off.
    scanner_ready = 1'b0;
    send_frame(32'h2000, 64'h00000123_456789AB, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      checkOutput("wait_opending", opending, 1);
      checkOutput("wait_in_ready", bus.in_ready, 0);
      checkOutput("wait_ostart", ostart, 0);
    end
    scanner_ready = 1'b1;
    @(negedge clk);
    checkOutput("b_ostart", ostart, 1);
    @(negedge clk);
    checkOutput("b_ostart_low", ostart, 0);
    scanner_ready = 1'b0;
    checkOutput("b_ok", oframes_ok, 2);

    // Collect a new frame while the previous job is still running.
    send_frame(32'h3000, 64'h0000ABCD_00001111, 1'b1);
    repeat (5) @(negedge clk);
    checkOutput("c_hold_template", oblock_template, make_tpl(32'h2000));
    checkOutput("c_hold_threshold", othreshold, 64'h00000123_456789AB);
    checkOutput("c_pending", opending, 1);
    scanner_ready = 1'b1;
    @(negedge clk);
    checkOutput("c_ostart", ostart, 1);
    checkOutput("c_template", oblock_template, make_tpl(32'h3000));
    @(negedge clk);
    checkOutput("c_ok", oframes_ok, 3);

    // Garbage words, then a frame ending early on word 10, then a good frame.
    send_word(32'hDEAD0001, 1'b0);
    send_word(32'h0BAD0002, 1'b1);
    send_word(MAGIC, 1'b1);
    @(negedge clk);
    checkOutput("garbage_bad", oframes_bad, 3);
    send_word(MAGIC, 1'b0);
    for (int k = 1; k < 10; k++) send_word(32'h5000 + k, 1'b0);
    send_word(32'h500A, 1'b1);
    @(negedge clk);
    checkOutput("short_bad", oframes_bad, 4);
    checkOutput("short_no_pending", opending, 0);
    send_frame(32'h4000, 64'h00000000_0000FFFF, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("d_bad", oframes_bad, 4);
    checkOutput("d_ok", oframes_ok, 4);
    checkOutput("d_pulses", pulses, 4);
    checkOutput("d_template", oblock_template, make_tpl(32'h4000));

    // Word 26 without in_last is dropped; the following MAGIC opens a new frame.
    send_word(MAGIC, 1'b0);
    for (int k = 0; k < 24; k++) send_word(32'h5100 + k, 1'b0);
    send_word(32'h11111111, 1'b0);
    send_word(32'h22222222, 1'b0);
    @(negedge clk);
    checkOutput("nolast_bad", oframes_bad, 5);
    checkOutput("nolast_pending", opending, 0);
    checkOutput("nolast_in_ready", bus.in_ready, 1);
    send_frame(32'h6000, 64'h00FF00FF_00FF00FF, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("e_ok", oframes_ok, 5);
    checkOutput("e_pulses", pulses, 5);
    checkOutput("e_threshold", othreshold, 64'h00FF00FF_00FF00FF);

    // Reset in the middle of collecting (word 12).
    send_word(MAGIC, 1'b0);
    for (int k = 1; k < 12; k++) send_word(32'h7000 + k, 1'b0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst1_template", oblock_template, 0);
    checkOutput("rst1_threshold", othreshold, 0);
    checkOutput("rst1_ok", oframes_ok, 0);
    checkOutput("rst1_bad", oframes_bad, 0);
    checkOutput("rst1_pending", opending, 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'h8000, 64'h00000001_00000002, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("f_ok", oframes_ok, 1);
    checkOutput("f_bad", oframes_bad, 0);
    checkOutput("f_word0", oblock_template[31:0], 32'h8000);

    // Reset while ostart is high.
    send_frame(32'h9000, 64'h0000FFFF_FFFF0000, 1'b1);
    @(negedge clk);
    @(negedge clk);
    checkOutput("g_ostart", ostart, 1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rst2_ostart", ostart, 0);
    checkOutput("rst2_template", oblock_template, 0);
    checkOutput("rst2_threshold", othreshold, 0);
    checkOutput("rst2_ok", oframes_ok, 0);
    @(negedge clk);
    rst = 1'b0;
    send_frame(32'hA000, 64'h12345678_9ABCDEF0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("h_ok", oframes_ok, 1);
    checkOutput("h_template", oblock_template, make_tpl(32'hA000));
    checkOutput("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
